// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, bus types and sequencer state encodings for pipe_ctrl.
// Optional perf counters in pipe_ctrl are enabled by PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

   localparam int unsigned REG_ADDR_W   = 5;
   localparam int unsigned INST_ADDR_W  = 32;
   localparam int unsigned PIPE_STATE_W = 2;

   typedef logic [REG_ADDR_W-1:0]   reg_addr_t;
   typedef logic [INST_ADDR_W-1:0]  inst_addr_t;
   typedef logic [PIPE_STATE_W-1:0] pipe_state_t;

   localparam logic [1:0] PC_ST_RUN    = 2'b00;
   localparam logic [1:0] PC_ST_LDUSE  = 2'b01;
   localparam logic [1:0] PC_ST_MCWAIT = 2'b10;

   // Counter only needs to reach timeout-1.
   function automatic int unsigned mc_cnt_width(input int unsigned timeout);
      int unsigned w;
      w = $clog2(timeout);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Combinational load-use detector: a load in EX whose rd feeds a source
// register read by the instruction in ID.
module pipe_ctrl_hazard_det
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic                  rs1_ren,
   input  logic                  rs2_ren,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic                  ex_load,
   output logic                  hazard
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = rs1_ren & (rs1_addr == ex_rd_addr);
   assign rs2_hit = rs2_ren & (rs2_addr == ex_rd_addr);
   // x0 is never written, so a load to x0 cannot create a dependency.
   assign hazard  = ex_load & (ex_rd_addr != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage load enables/flushes, EX jump redirect, load-use
// bubble and multi-cycle freeze with watchdog. PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MC_TIMEOUT = 64
`ifdef PIPE_CTRL_PERF_EN
   , parameter int unsigned CNT_W = 32
`endif
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
   input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
   input  logic                   id_rs1_ren,
   input  logic                   id_rs2_ren,
   input  logic [REG_ADDR_W-1:0]  id_ex_rd_addr,
   input  logic                   id_ex_load,
   input  logic                   ex_jump_req,
   input  logic [INST_ADDR_W-1:0] ex_jump_addr,
   input  logic                   ex_mc_start,
   input  logic                   ex_mc_done,
   output logic                   pc_lden,
   output logic                   pc_jump_en,
   output logic [INST_ADDR_W-1:0] pc_jump_addr,
   output logic                   if_id_lden,
   output logic                   id_ex_lden,
   output logic                   ex_mem_lden,
   output logic                   mem_wb_lden,
   output logic                   if_id_flush,
   output logic                   id_ex_flush,
   output logic                   ex_mem_flush,
   output logic                   mc_abort,
`ifdef PIPE_CTRL_PERF_EN
   output logic [CNT_W-1:0]       perf_stall_cyc,
   output logic [CNT_W-1:0]       perf_flush_cnt,
`endif
   output logic                   err_timeout
);

   localparam int unsigned     MC_W    = mc_cnt_width(MC_TIMEOUT);
   localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_TIMEOUT - 1);

   pipe_state_t     state_q, state_d;
   logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
   logic            err_q, err_d;
   logic            hazard;

   pipe_ctrl_hazard_det u_hazard_det (
      .rs1_addr   (id_rs1_addr),
      .rs2_addr   (id_rs2_addr),
      .rs1_ren    (id_rs1_ren),
      .rs2_ren    (id_rs2_ren),
      .ex_rd_addr (id_ex_rd_addr),
      .ex_load    (id_ex_load),
      .hazard     (hazard)
   );

   assign pc_jump_addr = ex_jump_addr;
   assign err_timeout  = err_q;

   always_comb begin
      state_d      = state_q;
      mc_cnt_d     = mc_cnt_q;
      err_d        = err_q;
      pc_lden      = 1'b1;
      if_id_lden   = 1'b1;
      id_ex_lden   = 1'b1;
      ex_mem_lden  = 1'b1;
      mem_wb_lden  = 1'b1;
      pc_jump_en   = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mc_abort     = 1'b0;

      case (state_q)
         PC_ST_RUN: begin
            if (ex_jump_req) begin
               pc_jump_en  = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (ex_mc_start) begin
               // A same-cycle done is a zero-wait op and flows like a normal instruction.
               if (!ex_mc_done) begin
                  pc_lden      = 1'b0;
                  if_id_lden   = 1'b0;
                  id_ex_lden   = 1'b0;
                  ex_mem_flush = 1'b1;
                  mc_cnt_d     = MC_W'(1);
                  state_d      = PC_ST_MCWAIT;
               end
            end else if (hazard) begin
               pc_lden     = 1'b0;
               if_id_lden  = 1'b0;
               id_ex_flush = 1'b1;
               state_d     = PC_ST_LDUSE;
            end
         end
         PC_ST_LDUSE: begin
            state_d = PC_ST_RUN;
         end
         PC_ST_MCWAIT: begin
            if (ex_mc_done) begin
               mc_cnt_d = '0;
               state_d  = PC_ST_RUN;
            end else if (mc_cnt_q == MC_LAST) begin
               mc_abort     = 1'b1;
               err_d        = 1'b1;
               ex_mem_flush = 1'b1;
               mc_cnt_d     = '0;
               state_d      = PC_ST_RUN;
            end else begin
               pc_lden      = 1'b0;
               if_id_lden   = 1'b0;
               id_ex_lden   = 1'b0;
               ex_mem_flush = 1'b1;
               mc_cnt_d     = mc_cnt_q + MC_W'(1);
            end
         end
         default: begin
            state_d  = PC_ST_RUN;
            mc_cnt_d = '0;
         end
      endcase

      // Reset holds every stage still regardless of state.
      if (rstn) begin
         pc_lden      = 1'b0;
         if_id_lden   = 1'b0;
         id_ex_lden   = 1'b0;
         ex_mem_lden  = 1'b0;
         mem_wb_lden  = 1'b0;
         pc_jump_en   = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_flush  = 1'b0;
         ex_mem_flush = 1'b0;
         mc_abort     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_q  <= PC_ST_RUN;
         mc_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mc_cnt_q <= mc_cnt_d;
         err_q    <= err_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_lden && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
         end
         if (pc_jump_en && (flush_q != '1)) begin
            flush_q <= flush_q + CNT_W'(1);
         end
      end
   end

   assign perf_stall_cyc = stall_q;
   assign perf_flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int unsigned T = 8;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic [REG_ADDR_W-1:0]  rs1, rs2, rd;
   logic                   ren1, ren2, ld, jreq, mcs, mcd;
   logic [INST_ADDR_W-1:0] jaddr;

   logic                   pc_lden, pc_jump_en, if_id_lden, id_ex_lden, ex_mem_lden, mem_wb_lden;
   logic                   if_id_flush, id_ex_flush, ex_mem_flush, mc_abort, err_timeout;
   logic [INST_ADDR_W-1:0] pc_jump_addr;
   logic [10:0]            ctl;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]            perf_stall_cyc, perf_flush_cnt;
   longint unsigned        m_stall, m_flush;
`endif

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   // Model state: pending bubble cycle, cycles spent waiting on the mc unit, sticky error.
   bit ld_bubble = 1'b0;
   int mc_wait   = 0;
   bit err_flag  = 1'b0;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .MC_TIMEOUT (T)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .id_rs1_addr   (rs1),
      .id_rs2_addr   (rs2),
      .id_rs1_ren    (ren1),
      .id_rs2_ren    (ren2),
      .id_ex_rd_addr (rd),
      .id_ex_load    (ld),
      .ex_jump_req   (jreq),
      .ex_jump_addr  (jaddr),
      .ex_mc_start   (mcs),
      .ex_mc_done    (mcd),
      .pc_lden       (pc_lden),
      .pc_jump_en    (pc_jump_en),
      .pc_jump_addr  (pc_jump_addr),
      .if_id_lden    (if_id_lden),
      .id_ex_lden    (id_ex_lden),
      .ex_mem_lden   (ex_mem_lden),
      .mem_wb_lden   (mem_wb_lden),
      .if_id_flush   (if_id_flush),
      .id_ex_flush   (id_ex_flush),
      .ex_mem_flush  (ex_mem_flush),
      .mc_abort      (mc_abort),
`ifdef PIPE_CTRL_PERF_EN
      .perf_stall_cyc (perf_stall_cyc),
      .perf_flush_cnt (perf_flush_cnt),
`endif
      .err_timeout   (err_timeout)
   );

   // {pc, if_id, id_ex, ex_mem, mem_wb lden, jump_en, if_id/id_ex/ex_mem flush, abort, err}
   assign ctl = {pc_lden, if_id_lden, id_ex_lden, ex_mem_lden, mem_wb_lden,
                 pc_jump_en, if_id_flush, id_ex_flush, ex_mem_flush, mc_abort, err_timeout};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rstn = 1'b0; rs1 = '0; rs2 = '0; rd = '0; ren1 = 1'b0; ren2 = 1'b0;
      ld = 1'b0; jreq = 1'b0; jaddr = '0; mcs = 1'b0; mcd = 1'b0;
   endtask

   // Settle, compare outputs against the model, then advance one clock.
   task automatic cycle(input string tag);
      bit haz, frz, e_pc, e_ifid, e_idex, e_jen, e_fi, e_fd, e_fe, e_ab;
      bit nb, nerr;
      int nmc;
      @(negedge clk);
      haz  = ld && (rd != 0) && ((ren1 && rs1 == rd) || (ren2 && rs2 == rd));
      frz  = 1'b0; e_pc = 1'b1; e_ifid = 1'b1; e_idex = 1'b1;
      e_jen = 1'b0; e_fi = 1'b0; e_fd = 1'b0; e_fe = 1'b0; e_ab = 1'b0;
      nb = 1'b0; nmc = mc_wait; nerr = err_flag;
      if (rstn) begin
         nmc = 0; nerr = 1'b0; frz = 1'b1;
      end else if (ld_bubble) begin
         nb = 1'b0;
      end else if (mc_wait > 0) begin
         if (mcd) nmc = 0;
         else if (mc_wait == int'(T) - 1) begin
            e_ab = 1'b1; e_fe = 1'b1; nerr = 1'b1; nmc = 0;
         end else begin
            e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_fe = 1'b1; nmc = mc_wait + 1;
         end
      end else if (jreq) begin
         e_jen = 1'b1; e_fi = 1'b1; e_fd = 1'b1;
      end else if (mcs) begin
         if (!mcd) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_fe = 1'b1; nmc = 1;
         end
      end else if (haz) begin
         e_pc = 1'b0; e_ifid = 1'b0; e_fd = 1'b1; nb = 1'b1;
      end
      if (frz) begin
         check({tag, "/ctl"}, 64'(ctl), 64'(0));
      end else begin
         check({tag, "/ctl"}, 64'(ctl), 64'({e_pc, e_ifid, e_idex, 2'b11,
                                             e_jen, e_fi, e_fd, e_fe, e_ab, err_flag}));
         if (e_jen) check({tag, "/addr"}, 64'(pc_jump_addr), 64'(jaddr));
      end
`ifdef PIPE_CTRL_PERF_EN
      check({tag, "/stall"}, 64'(perf_stall_cyc), 64'(m_stall));
      check({tag, "/flush"}, 64'(perf_flush_cnt), 64'(m_flush));
      if (rstn) begin
         m_stall = 0; m_flush = 0;
      end else begin
         if (!e_pc) m_stall++;
         if (e_jen) m_flush++;
      end
`endif
      @(posedge clk);
      #1;
      ld_bubble = nb; mc_wait = nmc; err_flag = nerr;
   endtask

   initial begin
      idle();
      rstn = 1'b1;
      cycle("reset0");
      cycle("reset1");
      rstn = 1'b0;
      cycle("run_idle");

      // Load x5 in EX, ID reads rs2 = x5: one stall cycle then the bubble cycle.
      ld = 1'b1; rd = 5'd5; rs2 = 5'd5; ren2 = 1'b1; rs1 = 5'd2; ren1 = 1'b1;
      #1 check("lu_stall_const", 64'(ctl), 64'({5'b00111, 6'b001000}));
      cycle("lu_stall");
      ld = 1'b0;
      cycle("lu_bubble");
      cycle("lu_after");

      // Same load with rd = x0, then with ID not reading x5: no stall.
      ld = 1'b1; rd = 5'd0; rs2 = 5'd0;
      cycle("lu_x0");
      rd = 5'd5; rs2 = 5'd6;
      cycle("lu_noread");
      idle();

      // Jump redirect with front-end flush.
      jreq = 1'b1; jaddr = 32'h0000_0100;
      #1 check("jmp_const", 64'(ctl), 64'({5'b11111, 6'b111000}));
      check("jmp_addr_const", 64'(pc_jump_addr), 64'h100);
      cycle("jump");
      idle();
      cycle("jump_after");

      // Multi-cycle op released by done five cycles after start.
      mcs = 1'b1;
      cycle("mc_start");
      mcs = 1'b0;
      #1 check("mc_frz_const", 64'(ctl), 64'({5'b00011, 6'b000100}));
      repeat (4) cycle("mc_wait");
      mcd = 1'b1;
      cycle("mc_done");
      mcd = 1'b0;
      ld = 1'b1; rd = 5'd7; rs1 = 5'd7; ren1 = 1'b1;
      cycle("mc_run_haz");
      idle();
      cycle("mc_run_bub");

      // Zero-wait multi-cycle op.
      mcs = 1'b1; mcd = 1'b1;
      cycle("mc_zero");
      idle();

      // Watchdog: abort in the 8th cycle counted from start.
      mcs = 1'b1;
      cycle("to_start");
      mcs = 1'b0;
      repeat (6) cycle("to_wait");
      #1 check("to_abort_const", 64'(ctl), 64'({5'b11111, 6'b000110}));
      cycle("to_abort");
      check("to_err_sticky", 64'(err_timeout), 64'(1));
      repeat (3) cycle("to_after");
      rstn = 1'b1;
      cycle("to_reset");
      rstn = 1'b0;
      check("to_err_clr", 64'(err_timeout), 64'(0));

      // Jump beats mc_start; then reset in the middle of MCWAIT.
      jreq = 1'b1; mcs = 1'b1; jaddr = 32'hdead_beef;
      cycle("jmp_vs_mc");
      idle();
      cycle("jmp_vs_mc_after");
      mcs = 1'b1;
      cycle("rst_mc_start");
      mcs = 1'b0;
      cycle("rst_mc_wait");
      rstn = 1'b1;
      #1 check("rst_mid_const", 64'(ctl), 64'(0));
      cycle("rst_mid");
      rstn = 1'b0;
      cycle("rst_run");

      for (int i = 0; i < 1500; i++) begin
         rstn  = ($urandom_range(0, 79) == 0);
         rs1   = REG_ADDR_W'($urandom_range(0, 3));
         rs2   = REG_ADDR_W'($urandom_range(0, 3));
         rd    = REG_ADDR_W'($urandom_range(0, 3));
         ren1  = $urandom_range(0, 1) == 1;
         ren2  = $urandom_range(0, 1) == 1;
         ld    = $urandom_range(0, 2) == 0;
         jreq  = $urandom_range(0, 7) == 0;
         jaddr = $urandom;
         mcs   = $urandom_range(0, 5) == 0;
         mcd   = $urandom_range(0, 9) == 0;
         cycle("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (pc, if_id, id_ex, ex_mem, mem_wb).
- Generates per-stage load-enable (lden) and flush controls, and redirects pc on EX-resolved jumps.
- Inserts a one-cycle load-use bubble, and freezes the front end while a multi-cycle EX unit (mul/div) works, with a timeout watchdog.
- Sits beside the stage registers; replaces the constant 1'b1 lden ties.

Parameters:
- MC_TIMEOUT, 64, max cycles in MCWAIT before forced abort (>=2).
- CNT_W, 32, width of performance counters (only used with PIPE_CTRL_PERF_EN).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rstn  in  1  reset; asynchronous, active-high (1 = reset asserted).
- id_rs1_addr  in  `RegAddrBus  rs1 index of instruction in ID.
- id_rs2_addr  in  `RegAddrBus  rs2 index of instruction in ID.
- id_rs1_ren  in  1  ID instruction reads rs1.
- id_rs2_ren  in  1  ID instruction reads rs2.
- id_ex_rd_addr  in  `RegAddrBus  rd of instruction in EX.
- id_ex_load  in  1  EX instruction is a load.
- ex_jump_req  in  1  EX resolved a taken branch/jump this cycle.
- ex_jump_addr  in  `InstAddrBus  jump target.
- ex_mc_start  in  1  EX instruction needs a multi-cycle unit.
- ex_mc_done  in  1  multi-cycle result valid (1-cycle pulse).
- pc_lden  out  1  pc advance enable.
- pc_jump_en  out  1  pc loads pc_jump_addr.
- pc_jump_addr  out  `InstAddrBus  jump target to pc.
- if_id_lden, id_ex_lden, ex_mem_lden, mem_wb_lden  out  1 each  stage load enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load NOP bubble on next edge (flush overrides lden).
- mc_abort  out  1  1-cycle pulse, multi-cycle op timed out.
- err_timeout  out  1  sticky timeout flag, cleared only by reset.

Behaviour:
- States: RUN (2'b00), LDUSE (2'b01), MCWAIT (2'b10). Reset -> RUN; mc counter = 0; err_timeout = 0.
- While rstn = 1: all lden = 0, all flush = 0, pc_jump_en = 0, mc_abort = 0.
- Control outputs are combinational from state and inputs. Zero added latency.
- hazard = id_ex_load & (id_ex_rd_addr != 0) & ((id_rs1_ren & rs1 == rd) | (id_rs2_ren & rs2 == rd)).
- Priority in RUN: ex_jump_req > ex_mc_start > hazard > normal.
- RUN, normal: all lden = 1, no flush.
- RUN, ex_jump_req: pc_jump_en = 1, pc_jump_addr = ex_jump_addr; if_id_flush = id_ex_flush = 1; stay RUN. ex_mc_start and hazard are ignored that cycle.
- RUN, ex_mc_start & ex_mc_done in the same cycle: zero-wait; normal behaviour; stay RUN.
- RUN, ex_mc_start alone: pc/if_id/id_ex lden = 0; ex_mem_flush = 1; counter <= 1; -> MCWAIT.
- RUN, hazard: pc_lden = if_id_lden = 0; id_ex_flush = 1; ex_mem/mem_wb lden = 1; -> LDUSE.
- LDUSE: lasts exactly one cycle; all lden = 1; hazard is not evaluated (id_ex holds the bubble); -> RUN.
- MCWAIT, no done: pc/if_id/id_ex lden = 0; ex_mem_flush = 1; mem_wb_lden = 1; counter += 1.
- MCWAIT, ex_mc_done: all lden = 1, no flush (ex_mem captures result); counter <= 0; -> RUN.
- MCWAIT, counter == MC_TIMEOUT-1 without done: mc_abort = 1; err_timeout <= 1; ex_mem_flush = 1 (result dropped); upstream lden = 1; -> RUN.
- ex_mc_done and the timeout in the same cycle: done wins; no abort.
- ex_jump_req while in MCWAIT or LDUSE is ignored; it is illegal by construction.
- Reset mid-MCWAIT: returns to RUN, counter cleared, no abort pulse.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cyc [CNT_W-1:0] and perf_flush_cnt [CNT_W-1:0], both reset to 0 and saturating at all-ones.
  - perf_stall_cyc increments each cycle pc_lden = 0 outside reset.
  - perf_flush_cnt increments on each pc_jump_en.
- Undefined: no perf ports, no counter logic.

Decomposition:
- defines.v: PC_ST_RUN/LDUSE/MCWAIT encodings, PipeStateBus width, MC counter width macro.
- Sub-module hazard_det: purely combinational load-use compare, producing hazard.

Test Plan:
- Load x5 in EX, ID reads rs2 = x5 -> exactly 1 cycle with pc_lden = if_id_lden = 0 and id_ex_flush = 1; LDUSE next; then all lden = 1.
- Same load with rd = x0 -> no stall. Same load with ID not reading x5 -> no stall.
- ex_jump_req = 1, addr 0x0000_0100 -> pc_jump_en = 1 with that address; if_id_flush = id_ex_flush = 1 for one cycle; no state change.
- ex_mc_start, then ex_mc_done 5 cycles later -> 5 frozen cycles with ex_mem_flush = 1; release on the done cycle; state RUN.
- MC_TIMEOUT = 8, no done -> mc_abort pulse in the 8th cycle; err_timeout stays 1; reset clears it.
- Jump and mc_start together, then reset asserted mid-MCWAIT -> jump wins, MCWAIT never entered. Separate run: reset mid-MCWAIT -> all lden = 0 during reset, RUN after; with PIPE_CTRL_PERF_EN, counters read 0.
